// File: rtl/rs232_pkg.sv
// Shared RS232 buffer parameters.
// Used by the receive and transmit side FIFOs.
package rs232_pkg;

    localparam int DEPTH_LOG2_DEF = 4;
    localparam int DATA_W         = 8;

endpackage

// File: rtl/rs232_fifo_ram.sv
// Register array with one write port and one asynchronous read port.
// Ports: clk, rst (async active-low clear), we/wa/wd write, ra/rd read.
module rs232_fifo_ram
    import rs232_pkg::*;
#(
    parameter int AW = DEPTH_LOG2_DEF,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign rd = mem_q[ra];

endmodule

// File: rtl/rs232_rxfifo.sv
// Receive FIFO draining the RS232 receiver into a FWFT buffer for the CPU.
// Ports: rx_rdy/rx_data/rx_done to receiver; rd/rd_data/rd_rdy/count/ovr/clr_ovr to CPU.
module rs232_rxfifo
    import rs232_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_rdy,
    input  logic [DATA_W-1:0]   rx_data,
    output logic                rx_done,
    input  logic                rd,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_rdy,
    output logic [DEPTH_LOG2:0] count,
    output logic                ovr,
    input  logic                clr_ovr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  rx_done_q;
    logic                  ovr_q, ovr_d;

    logic cap, full, empty, rd_eff, wr, ovr_set;

    // rx_done_q masks the cycle the receiver still holds rdy high.
    assign cap     = rx_rdy & ~rx_done_q;
    assign full    = (count_q == FULL);
    assign empty   = (count_q == '0);
    assign rd_eff  = rd & ~empty;
    // A read in the same cycle frees the slot for the incoming byte.
    assign wr      = cap & (~full | rd);
    assign ovr_set = cap & full & ~rd;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        if (wr) wp_d = wp_q + 1'b1;
        if (rd_eff) rp_d = rp_q + 1'b1;
        if (wr && !rd_eff) begin
            count_d = count_q + 1'b1;
        end else if (rd_eff && !wr) begin
            count_d = count_q - 1'b1;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            rx_done_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            rx_done_q <= cap;
            ovr_q     <= ovr_d;
        end
    end

    rs232_fifo_ram #(
        .AW (DEPTH_LOG2),
        .DW (DATA_W)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (wr),
        .wa  (wp_q),
        .wd  (rx_data),
        .ra  (rp_q),
        .rd  (rd_data)
    );

    assign rx_done = rx_done_q;
    assign rd_rdy  = ~empty;
    assign count   = count_q;
    assign ovr     = ovr_q;

endmodule
